// File: rtl/hart_pkg.sv
// ---------------------------------------------------------------------------
// hart_pkg
//   Shared types for the hart front end.
//   XLEN / ILEN      : address and instruction widths.
//   fetch_state_e    : prefetch control state {RUN, TRAP_DRAIN, HALT}.
//   queue_entry_t    : one instruction-queue entry {inst, pc, trap}.
// ---------------------------------------------------------------------------
package hart_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    TRAP_DRAIN = 2'd1,
    HALT       = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ILEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic            trap;
  } queue_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
//   Single-clock FIFO with registered storage; the head entry is read
//   straight out of the storage array, so there is no output latency.
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset
//     flush        : empties the FIFO at the next edge (wins over push/pop)
//     push, push_data : write request; accepted when not full, or when a
//                       pop happens in the same cycle
//     pop          : removes the head entry when not empty
//     head_data    : current head entry
//     full, empty, count : occupancy status
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign do_pop    = pop && !empty;
  // A full FIFO still takes a write when the head leaves in the same cycle.
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/prefetch_unit.sv
// ---------------------------------------------------------------------------
// prefetch_unit
//   Sequential instruction prefetcher with a credit-limited imem request
//   port and an instruction queue toward decode.
//   Ports:
//     clk, rst_n                          : clock, async active-low reset
//     o_imem_req_valid / i_imem_req_ready : request handshake
//     o_imem_req_addr                     : word-aligned fetch address
//     i_imem_rsp_valid / i_imem_rsp_data  : in-order responses, no backpressure
//     o_inst_valid / i_inst_ready         : queue head handshake toward decode
//     o_inst, o_inst_pc, o_inst_trap      : queue head contents
//     i_redirect, i_redirect_pc           : flush and restart fetch
//     o_count                             : queue occupancy
//     o_dbg_state                         : current fetch state (debug)
//
//   Handshakes: a transfer happens on a rising edge where valid and ready
//   are both high; valid never depends on ready in the same direction.
//   Responses cannot be stalled, which is why a request is only issued
//   when the queue has a guaranteed free slot for it.
// ---------------------------------------------------------------------------
module prefetch_unit
  import hart_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_ADDR      = 32'h0000_0000,
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       o_imem_req_valid,
  input  logic                       i_imem_req_ready,
  output logic [XLEN-1:0]            o_imem_req_addr,
  input  logic                       i_imem_rsp_valid,
  input  logic [ILEN-1:0]            i_imem_rsp_data,
  output logic                       o_inst_valid,
  input  logic                       i_inst_ready,
  output logic [ILEN-1:0]            o_inst,
  output logic [XLEN-1:0]            o_inst_pc,
  output logic                       o_inst_trap,
  input  logic                       i_redirect,
  input  logic [XLEN-1:0]            i_redirect_pc,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output fetch_state_e               o_dbg_state
);

  localparam int OW = $clog2(MAX_OUTSTANDING+1);

  fetch_state_e  state;
  fetch_state_e  state_next;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;       // PC belonging to the next kept response
  logic [OW-1:0]   outstanding;
  logic [OW-1:0]   discard;      // stale responses still to be dropped

  logic            credit_ok;
  logic            room_ok;
  logic            req_fire;
  logic            rsp_keep;
  logic            trap_push;
  logic            fifo_push;
  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  queue_entry_t    push_entry;
  queue_entry_t    head_entry;

  assign credit_ok = (32'(outstanding) < 32'(MAX_OUTSTANDING));
  // Every in-flight request already owns a queue slot.
  assign room_ok   = ((32'(o_count) + 32'(outstanding)) < 32'(DEPTH));

  // Gated with rst_n so valid is low during reset yet a request to
  // RESET_ADDR is visible in the very first cycle after release.
  assign o_imem_req_valid = rst_n && (state == RUN) && !i_redirect &&
                            credit_ok && room_ok;
  assign o_imem_req_addr  = {fetch_pc[XLEN-1:2], 2'b00};
  assign req_fire         = o_imem_req_valid && i_imem_req_ready;

  assign rsp_keep  = i_imem_rsp_valid && !i_redirect && (discard == '0);
  // discard == 0 in TRAP_DRAIN also means nothing is outstanding, so a trap
  // marker and a kept response never compete for the write port.
  assign trap_push = (state == TRAP_DRAIN) && !i_redirect && (discard == '0);
  assign fifo_push = rsp_keep || trap_push;

  always_comb begin
    push_entry = '0;
    if (trap_push) begin
      push_entry.inst = '0;
      push_entry.pc   = fetch_pc;
      push_entry.trap = 1'b1;
    end else begin
      push_entry.inst = i_imem_rsp_data;
      push_entry.pc   = rsp_pc;
      push_entry.trap = 1'b0;
    end
  end

  assign o_inst_valid = !fifo_empty && !i_redirect;
  assign fifo_pop     = o_inst_valid && i_inst_ready;
  assign o_inst       = head_entry.inst;
  assign o_inst_pc    = head_entry.pc;
  assign o_inst_trap  = head_entry.trap;
  assign o_dbg_state  = state;

  sync_fifo #(
    .WIDTH ($bits(queue_entry_t)),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (i_redirect),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head_data (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (o_count)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (i_redirect) begin
      state_next = (i_redirect_pc[1:0] == 2'b00) ? RUN : TRAP_DRAIN;
    end else begin
      case (state)
        TRAP_DRAIN: if (discard == '0) state_next = HALT;
        default:    state_next = state;
      endcase
    end
  end

  // ------------------------------------------------- credits and PCs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_ADDR;
      rsp_pc      <= RESET_ADDR;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      // No request is issued while i_redirect is high, so this also
      // covers the redirect cycle.
      case ({req_fire, i_imem_rsp_valid})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: outstanding <= outstanding;
      endcase

      if (i_redirect) begin
        discard  <= i_imem_rsp_valid ? (outstanding - OW'(1)) : outstanding;
        fetch_pc <= i_redirect_pc;
        rsp_pc   <= i_redirect_pc;
      end else begin
        if (i_imem_rsp_valid && (discard != '0)) discard <= discard - OW'(1);
        if (req_fire) fetch_pc <= fetch_pc + 32'd4;
        if (rsp_keep) rsp_pc   <= rsp_pc + 32'd4;
      end
    end
  end

  // The credit rule must make a write into a full queue impossible.
  assert property (@(posedge clk) disable iff (!rst_n)
                   !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_prefetch_unit.sv
// ---------------------------------------------------------------------------
// tb_prefetch_unit
//   Random and directed stimulus for prefetch_unit. An imem model answers
//   requests in order; every response that should survive is pushed into
//   exp_q when it is driven, and a monitor pops and compares whenever decode
//   takes an instruction. Redirects and resets are modelled by epochs: a
//   response whose request belongs to an older epoch must vanish.
// ---------------------------------------------------------------------------
module tb_prefetch_unit;
  import hart_pkg::*;

  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;
  localparam int DEPTH   = 4;
  localparam int MAX_OUT = 2;
  localparam int EW      = 65;

  // ------------------------------------------------------ clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         o_imem_req_valid;
  logic         i_imem_req_ready = 1'b0;
  logic [31:0]  o_imem_req_addr;
  logic         i_imem_rsp_valid = 1'b0;
  logic [31:0]  i_imem_rsp_data = '0;
  logic         o_inst_valid;
  logic         i_inst_ready = 1'b0;
  logic [31:0]  o_inst;
  logic [31:0]  o_inst_pc;
  logic         o_inst_trap;
  logic         i_redirect = 1'b0;
  logic [31:0]  i_redirect_pc = '0;
  logic [2:0]   o_count;
  fetch_state_e dbg_state;

  prefetch_unit #(
    .RESET_ADDR      (RESET_ADDR),
    .DEPTH           (DEPTH),
    .MAX_OUTSTANDING (MAX_OUT)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .o_imem_req_valid (o_imem_req_valid),
    .i_imem_req_ready (i_imem_req_ready),
    .o_imem_req_addr  (o_imem_req_addr),
    .i_imem_rsp_valid (i_imem_rsp_valid),
    .i_imem_rsp_data  (i_imem_rsp_data),
    .o_inst_valid     (o_inst_valid),
    .i_inst_ready     (i_inst_ready),
    .o_inst           (o_inst),
    .o_inst_pc        (o_inst_pc),
    .o_inst_trap      (o_inst_trap),
    .i_redirect       (i_redirect),
    .i_redirect_pc    (i_redirect_pc),
    .o_count          (o_count),
    .o_dbg_state      (dbg_state)
  );

  // ------------------------------------------------------ model state
  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          cyc;
  } pend_t;

  pend_t         pend_q[$];   // requests accepted by the imem model
  logic [EW-1:0] exp_q[$];    // {inst, pc, trap} decode should see, in order

  int          checks = 0;
  int          errors = 0;
  int          cycle = 0;
  int          epoch = 0;
  logic [31:0] exp_fetch_pc = RESET_ADDR;
  bit          halted = 0;
  bit          trap_mode = 0;
  bit          kept_now = 0;
  bit          was_reset = 0;
  bit          want_stream = 0;
  bit          want_empty = 0;
  int          want_count = -1;
  int          dec_pct = 100;
  int          req_pct = 100;
  int          rsp_pct = 100;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  task automatic check(input string name, input logic [95:0] act,
                       input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // ------------------------------------------------------ driver tasks
  task automatic drive(input bit redir, input logic [31:0] tgt);
    pend_t       p;
    logic [31:0] d;
    @(posedge clk);
    #1;
    cycle++;
    i_inst_ready     = ($urandom_range(0, 99) < dec_pct);
    i_imem_req_ready = ($urandom_range(0, 99) < req_pct);
    kept_now         = 0;
    i_imem_rsp_valid = 1'b0;
    i_imem_rsp_data  = $urandom;
    if (pend_q.size() != 0 && pend_q[0].cyc < cycle &&
        $urandom_range(0, 99) < rsp_pct) begin
      p = pend_q.pop_front();
      d = imem_word(p.addr);
      i_imem_rsp_valid = 1'b1;
      i_imem_rsp_data  = d;
      if (p.epoch == epoch && !redir) begin
        exp_q.push_back({d, p.addr, 1'b0});
        kept_now = 1;
      end
    end
    i_redirect    = redir;
    i_redirect_pc = tgt;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n            = 1'b0;
    i_imem_rsp_valid = 1'b0;
    i_redirect       = 1'b0;
    i_imem_req_ready = 1'b1;
    i_inst_ready     = 1'b1;
    kept_now         = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) drive(0, 32'h0);
  endtask

  task automatic drain();
    req_pct = 0; rsp_pct = 100; dec_pct = 100;
    run(12);
    want_empty = 1;
    run(1);
    want_empty = 0;
    req_pct = 100;
  endtask

  // ------------------------------------------------------ monitor / scoreboard
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_inst_valid", o_inst_valid, 0);
        check("rst_count", o_count, 0);
        check("rst_req_valid", o_imem_req_valid, 0);
        exp_q.delete();
        pend_q.delete();
        epoch++;
        exp_fetch_pc = RESET_ADDR;
        halted       = 0;
        trap_mode    = 0;
        was_reset    = 1;
      end else begin
        if (was_reset) begin
          check("first_req_valid", o_imem_req_valid, 1);
          check("first_req_addr", o_imem_req_addr, RESET_ADDR);
          was_reset = 0;
        end
        if (i_redirect) begin
          check("redir_inst_valid", o_inst_valid, 0);
          check("redir_req_valid", o_imem_req_valid, 0);
          exp_q.delete();
          epoch++;
          exp_fetch_pc = i_redirect_pc;
          halted       = (i_redirect_pc[1:0] != 2'b00);
          trap_mode    = halted;
          if (halted) exp_q.push_back({32'h0, i_redirect_pc, 1'b1});
        end else begin
          if (halted) check("halt_no_req", o_imem_req_valid, 0);
          if (halted && !trap_mode) check("halt_state", dbg_state, HALT);
          if (!trap_mode) check("count", o_count, exp_q.size() - int'(kept_now));
          if (want_count >= 0) check("count_hold", o_count, want_count);
          if (want_stream) check("stream_valid", o_inst_valid, 1);
          if (want_empty) check("exp_drained", exp_q.size(), 0);
          if (o_imem_req_valid && i_imem_req_ready) begin
            check("req_addr", o_imem_req_addr, exp_fetch_pc);
            pend_q.push_back('{exp_fetch_pc, epoch, cycle});
            exp_fetch_pc = exp_fetch_pc + 32'd4;
          end
          if (o_inst_valid && i_inst_ready) begin
            if (exp_q.size() <= int'(kept_now)) begin
              checks++;
              errors++;
              $display("FAIL inst_unexpected: got pc %0h with nothing expected (cycle %0d)",
                       o_inst_pc, cycle);
            end else begin
              e = exp_q.pop_front();
              check("inst_word", o_inst, e[64:33]);
              check("inst_pc", o_inst_pc, e[32:1]);
              check("inst_trap", o_inst_trap, e[0]);
              if (e[0]) trap_mode = 0;
            end
          end
        end
      end
    end
  end

  // ------------------------------------------------------ stimulus
  initial begin
    logic [31:0] tgt;

    // Warm-up stream: fetch 0, 4, 8 ... one per cycle.
    do_reset();
    run(2);
    want_stream = 1;
    run(10);
    want_stream = 0;

    // Decode stalled: the queue fills to exactly DEPTH and holds.
    dec_pct = 0;
    run(10);
    want_count = DEPTH;
    run(4);
    want_count = -1;
    dec_pct = 100;
    run(10);

    // Redirect with two requests in flight; late responses are stale.
    rsp_pct = 0;
    run(3);
    drive(1, 32'h0000_0100);
    rsp_pct = 100;
    run(10);

    // Misaligned redirect: one trap marker, then silence until 0x200.
    drive(1, 32'h0000_0102);
    run(10);
    drain();
    drive(1, 32'h0000_0200);
    run(10);

    // Reset pulse mid-stream with requests outstanding.
    rsp_pct = 0;
    run(3);
    rsp_pct = 100;
    do_reset();
    run(10);

    // Response collides with a redirect; fetch PC wraps past 0xFFFFFFFC.
    rsp_pct = 0;
    run(3);
    rsp_pct = 100;
    drive(1, 32'hFFFF_FFF8);
    run(12);
    drain();

    // Randomized traffic with random redirects.
    for (int blk = 0; blk < 40; blk++) begin
      dec_pct = $urandom_range(20, 100);
      req_pct = $urandom_range(20, 100);
      rsp_pct = $urandom_range(20, 100);
      for (int k = 0; k < 50; k++) begin
        if (halted ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 49) == 0)) begin
          tgt = 32'($urandom_range(0, 1023)) << 2;
          if (!halted && $urandom_range(0, 4) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
          drive(1, tgt);
        end else begin
          drive(0, 32'h0);
        end
      end
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
